tour_cmd_sequencer: RTL and testbench

//  Sits upstream of RemoteComm and replays a stored Knight command list over the UART link.
//  - Issues one 16-bit command per step and waits for cmd_snt, then for the DUT's response byte.
//  - Advances only on a positive ack (8'hA5).
//  - Used to drive whole board sweeps (gyro cal, then a move list) without a hand-written per-move test sequence.

---
 rtl/tour_cmd_sequencer_if.sv | 28 ++
 rtl/tour_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_tour_cmd_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tour_cmd_sequencer_if.sv
// Link between the command sequencer and RemoteComm: one 16-bit command word
// with a send strobe going out, and transmit-complete plus response-byte
// strobes coming back.
interface tour_cmd_sequencer_if;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;

    // Sequencer side: issues commands, consumes RemoteComm status.
    modport master (
        output cmd,
        output snd_cmd,
        input  cmd_snt,
        input  resp_rdy,
        input  resp
    );

    // RemoteComm side: accepts commands, reports progress and the reply byte.
    modport slave (
        input  cmd,
        input  snd_cmd,
        output cmd_snt,
        output resp_rdy,
        output resp
    );
endinterface

// File: rtl/tour_cmd_sequencer.sv
// Replays a stored list of Knight command words over RemoteComm. Each entry is
// sent, the transmit-complete pulse is awaited, then the reply byte; only a
// positive ack advances to the next entry. Bad replies, reply timeouts and
// operator aborts end playback with a sticky error and a reason code.
module tour_cmd_sequencer #(
    parameter int               DEPTH   = 16,
    parameter int               TO_W    = 24,
    parameter logic [TO_W-1:0]  TO_CYC  = 24'hF00000,
    parameter logic [7:0]       POS_ACK = 8'hA5,
    localparam int              AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [AW-1:0]            i_wr_addr,
    input  logic [15:0]              i_wr_data,
    input  logic [AW:0]              i_num_cmds,
    input  logic                     i_start,
    input  logic                     i_abort,
    tour_cmd_sequencer_if.master     bus,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic [1:0]               o_err_code,
    output logic [AW-1:0]            o_cmd_idx
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_SEND      = 3'd2;
    localparam logic [2:0] ST_WAIT_SNT  = 3'd3;
    localparam logic [2:0] ST_WAIT_RESP = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;
    localparam logic [2:0] ST_ERR       = 3'd6;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BADRESP = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    // Last counter value before the reply window closes; the transition to
    // ERR happens on the clock that would bring the count to TO_CYC.
    localparam logic [TO_W-1:0] TO_LAST  = TO_CYC - TO_W'(1'b1);
    localparam logic [TO_W-1:0] TO_MAX   = {TO_W{1'b1}};
    localparam logic [AW:0]     NUM_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0]     NUM_ZERO = {(AW+1){1'b0}};

    logic [15:0]     r_table [DEPTH];

    logic [2:0]      r_state;
    logic [15:0]     r_cmd;
    logic            r_snd_cmd;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [1:0]      r_err_code;
    logic [AW-1:0]   r_cmd_idx;
    logic [AW:0]     r_num;
    logic [TO_W-1:0] r_to_cnt;

    logic [2:0]      w_state_nxt;
    logic [15:0]     w_cmd_nxt;
    logic            w_snd_cmd_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;
    logic [1:0]      w_err_code_nxt;
    logic [AW-1:0]   w_cmd_idx_nxt;
    logic [AW:0]     w_num_nxt;
    logic [TO_W-1:0] w_to_cnt_nxt;
    logic            w_last;
    logic            w_to_hit;
    logic [TO_W-1:0] w_to_inc;

    // The current entry is the last one when its index reaches num_cmds-1;
    // r_num is never zero while playback is running.
    assign w_last   = ({1'b0, r_cmd_idx} == (r_num - (AW+1)'(1'b1)));
    assign w_to_hit = (r_to_cnt >= TO_LAST);
    // The reply counter saturates instead of wrapping back to zero.
    assign w_to_inc = (r_to_cnt == TO_MAX) ? r_to_cnt : (r_to_cnt + TO_W'(1'b1));

    // Command table: writable only while no playback is running, never reset.
    always_ff @(posedge clk) begin
        if (i_wr_en && !r_busy) begin
            r_table[i_wr_addr] <= i_wr_data;
        end
    end

    // Next-state and next-output decode for the playback sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_cmd_nxt      = r_cmd;
        w_snd_cmd_nxt  = 1'b0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_err_nxt      = r_err;
        w_err_code_nxt = r_err_code;
        w_cmd_idx_nxt  = r_cmd_idx;
        w_num_nxt      = r_num;
        w_to_cnt_nxt   = r_to_cnt;

        if (r_busy && i_abort) begin
            // Abort wins over any reply or timeout seen in the same cycle.
            w_state_nxt    = ST_ERR;
            w_busy_nxt     = 1'b0;
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_ABORT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_err_nxt      = 1'b0;
                        w_err_code_nxt = ERR_NONE;
                        w_cmd_idx_nxt  = {AW{1'b0}};
                        if (i_num_cmds != NUM_ZERO) begin
                            w_state_nxt = ST_LOAD;
                            w_busy_nxt  = 1'b1;
                            w_done_nxt  = 1'b0;
                            // Oversized lengths are clamped so the index never wraps.
                            if (i_num_cmds > NUM_MAX) begin
                                w_num_nxt = NUM_MAX;
                            end else begin
                                w_num_nxt = i_num_cmds;
                            end
                        end else begin
                            // Empty list: trivially complete, nothing is sent.
                            w_done_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    w_cmd_nxt     = r_table[r_cmd_idx];
                    w_snd_cmd_nxt = 1'b1;
                    w_state_nxt   = ST_SEND;
                end
                ST_SEND: begin
                    w_state_nxt = ST_WAIT_SNT;
                end
                ST_WAIT_SNT: begin
                    // A stray reply before transmission completes is ignored.
                    if (bus.cmd_snt) begin
                        w_state_nxt  = ST_WAIT_RESP;
                        w_to_cnt_nxt = {TO_W{1'b0}};
                    end else begin
                        w_state_nxt = ST_WAIT_SNT;
                    end
                end
                ST_WAIT_RESP: begin
                    w_to_cnt_nxt = w_to_inc;
                    if (bus.resp_rdy) begin
                        if (bus.resp == POS_ACK) begin
                            if (w_last) begin
                                w_state_nxt = ST_DONE;
                                w_busy_nxt  = 1'b0;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_state_nxt   = ST_LOAD;
                                w_cmd_idx_nxt = r_cmd_idx + AW'(1'b1);
                            end
                        end else begin
                            w_state_nxt    = ST_ERR;
                            w_busy_nxt     = 1'b0;
                            w_err_nxt      = 1'b1;
                            w_err_code_nxt = ERR_BADRESP;
                        end
                    end else if (w_to_hit) begin
                        w_state_nxt    = ST_ERR;
                        w_busy_nxt     = 1'b0;
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = ERR_TIMEOUT;
                    end else begin
                        w_state_nxt = ST_WAIT_RESP;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_ERR: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet idle.
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cmd      <= 16'h0000;
            r_snd_cmd  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_cmd_idx  <= {AW{1'b0}};
            r_num      <= NUM_ZERO;
            r_to_cnt   <= {TO_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_cmd      <= w_cmd_nxt;
            r_snd_cmd  <= w_snd_cmd_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
            r_cmd_idx  <= w_cmd_idx_nxt;
            r_num      <= w_num_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
        end
    end

    assign bus.cmd     = r_cmd;
    assign bus.snd_cmd = r_snd_cmd;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_err_code  = r_err_code;
    assign o_cmd_idx   = r_cmd_idx;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Scoreboard bench for tour_cmd_sequencer: expected command words are queued as
// each run is launched, a monitor pops and compares on every snd_cmd, and a
// RemoteComm model answers with cmd_snt and a reply byte.
module tb_tour_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  num_cmds;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [3:0]  cmd_idx;

    tour_cmd_sequencer_if bus ();

    tour_cmd_sequencer #(
        .DEPTH   (16),
        .TO_W    (24),
        .TO_CYC  (24'd100),
        .POS_ACK (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_num_cmds (num_cmds),
        .i_start    (start),
        .i_abort    (abort),
        .bus        (bus),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err),
        .o_err_code (err_code),
        .o_cmd_idx  (cmd_idx)
    );

    always #5 clk = ~clk;

    int          errors  = 0;
    int          checks  = 0;
    int          snd_cnt = 0;
    int          base;
    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;
    int          rsp_mode = 0;      // 0 silent, 1 cmd_snt + reply, 2 cmd_snt only
    logic [3:0]  bad_idx  = 4'hF;   // entry that gets answered 8'h5A

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] n);
        @(posedge clk); #1;
        start = 1'b1; num_cmds = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_snd(input int lim);
        int n = 0;
        while (n < lim) begin
            @(negedge clk);
            if (bus.snd_cmd === 1'b1) break;
            n++;
        end
        chk("wait_snd_bound", 32'(n < lim), 32'd1);
    endtask

    task automatic wait_end(input int lim);
        int n = 0;
        while (n < lim) begin
            @(negedge clk);
            if (done === 1'b1 || err === 1'b1) break;
            n++;
        end
        chk("wait_end_bound", 32'(n < lim), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0000;
        num_cmds = 5'd3; start = 1'b1; abort = 1'b0;
        bus.cmd_snt = 1'b0; bus.resp_rdy = 1'b0; bus.resp = 8'h00;

        fork
            // Monitor: every snd_cmd must match the next queued command word.
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1 && bus.snd_cmd === 1'b1) begin
                    snd_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_snd: got cmd %0h, expected no send", bus.cmd);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (bus.cmd !== mon_exp) begin
                            errors++;
                            $display("FAIL cmd_word: got %0h, expected %0h", bus.cmd, mon_exp);
                        end
                    end
                end
            end
            // RemoteComm model: cmd_snt 3 clocks after snd_cmd, reply 3 later.
            forever begin
                @(negedge clk);
                if (bus.snd_cmd === 1'b1 && rsp_mode != 0) begin
                    repeat (3) @(posedge clk);
                    #1 bus.cmd_snt = 1'b1;
                    @(posedge clk);
                    #1 bus.cmd_snt = 1'b0;
                    if (rsp_mode == 1) begin
                        repeat (2) @(posedge clk);
                        #1;
                        bus.resp     = (cmd_idx == bad_idx) ? 8'h5A : 8'hA5;
                        bus.resp_rdy = 1'b1;
                        @(posedge clk);
                        #1 bus.resp_rdy = 1'b0;
                    end
                end
            end
        join_none

        // Reset held over posedges with start asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd",      32'(bus.cmd),     32'h0);
        chk("rst_snd_cmd",  32'(bus.snd_cmd), 32'h0);
        chk("rst_busy",     32'(busy),        32'h0);
        chk("rst_done",     32'(done),        32'h0);
        chk("rst_err",      32'(err),         32'h0);
        chk("rst_err_code", 32'(err_code),    32'h0);
        chk("rst_cmd_idx",  32'(cmd_idx),     32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'h0);

        wr(4'd0, 16'h2000);
        wr(4'd1, 16'h53F4);
        wr(4'd2, 16'h47F1);
        wr(4'd3, 16'h1234);

        // Three-entry sweep, all acked; write and restart attempts while busy.
        rsp_mode = 1;
        base = snd_cnt;
        exp_q.push_back(16'h2000);
        exp_q.push_back(16'h53F4);
        exp_q.push_back(16'h47F1);
        start_run(5'd3);
        wait_snd(50);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'hFFFF; start = 1'b1; num_cmds = 5'd1;
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        wait_end(500);
        chk("run3_done",    32'(done),    32'h1);
        chk("run3_err",     32'(err),     32'h0);
        chk("run3_idx",     32'(cmd_idx), 32'h2);
        @(negedge clk);
        chk("run3_busy",    32'(busy),    32'h0);
        chk("run3_sends",   32'(snd_cnt - base), 32'd3);
        chk("run3_sb_left", 32'(exp_q.size()),   32'd0);

        // Entry 1 answered 8'h5A; entry 1 must still hold 16'h53F4.
        bad_idx = 4'd1;
        base = snd_cnt;
        exp_q.push_back(16'h2000);
        exp_q.push_back(16'h53F4);
        start_run(5'd3);
        wait_end(500);
        chk("bad_err",      32'(err),      32'h1);
        chk("bad_code",     32'(err_code), 32'h1);
        chk("bad_idx",      32'(cmd_idx),  32'h1);
        chk("bad_done",     32'(done),     32'h0);
        repeat (10) @(negedge clk);
        chk("bad_sends",    32'(snd_cnt - base), 32'd2);
        chk("bad_sb_left",  32'(exp_q.size()),   32'd0);
        bad_idx = 4'hF;

        // Reply timeout: cmd_snt arrives, no reply ever follows.
        rsp_mode = 2;
        exp_q.push_back(16'h2000);
        start_run(5'd1);
        begin
            int n = 0;
            while (n < 50) begin
                @(negedge clk);
                if (bus.cmd_snt === 1'b1) break;
                n++;
            end
            chk("to_cmd_snt_bound", 32'(n < 50), 32'd1);
        end
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("to_99_err",    32'(err),      32'h0);
        chk("to_99_busy",   32'(busy),     32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("to_100_err",   32'(err),      32'h1);
        chk("to_100_code",  32'(err_code), 32'h2);
        chk("to_100_busy",  32'(busy),     32'h0);
        chk("to_idx",       32'(cmd_idx),  32'h0);

        // Abort in WAIT_SNT of entry 0; the late cmd_snt/reply change nothing.
        rsp_mode = 1;
        base = snd_cnt;
        exp_q.push_back(16'h2000);
        start_run(5'd2);
        wait_snd(50);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_err",    32'(err),      32'h1);
        chk("abort_code",   32'(err_code), 32'h3);
        chk("abort_idx",    32'(cmd_idx),  32'h0);
        chk("abort_busy",   32'(busy),     32'h0);
        chk("abort_done",   32'(done),     32'h0);
        chk("abort_sends",  32'(snd_cnt - base), 32'd1);

        // Abort while idle is ignored.
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", 32'(busy), 32'h0);
        chk("idle_abort_code", 32'(err_code), 32'h3);

        // Empty list: done at once, error cleared, nothing sent.
        base = snd_cnt;
        start_run(5'd0);
        @(negedge clk);
        chk("zero_done",    32'(done), 32'h1);
        chk("zero_err",     32'(err),  32'h0);
        chk("zero_busy",    32'(busy), 32'h0);
        repeat (10) @(negedge clk);
        chk("zero_sends",   32'(snd_cnt - base), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
